// File: rtl/free_list_pkg.sv
// Shared sizing, types and pointer-wrap helper for the R10K physical-register free list.
package free_list_pkg;

    localparam int N        = 3;
    localparam int PRF_SZ   = 60;
    localparam int ARCH_SZ  = 32;
    localparam int FL_SZ    = PRF_SZ - ARCH_SZ;
    localparam int PRN_W    = $clog2(PRF_SZ);
    localparam int FL_IDX_W = $clog2(FL_SZ);
    localparam int FL_CNT_W = $clog2(FL_SZ + 1);
    localparam int NCNT_W   = $clog2(N + 1);

    typedef logic [PRN_W-1:0]    prn_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    // FL_SZ is not a power of two, so the modulo is an explicit compare-and-subtract.
    function automatic fl_idx_t fl_wrap(input fl_idx_t ptr, input fl_idx_t inc);
        logic [FL_IDX_W:0] sum;
        sum = {1'b0, ptr} + {1'b0, inc};
        if (sum >= (FL_IDX_W+1)'(FL_SZ))
            sum = sum - (FL_IDX_W+1)'(FL_SZ);
        return sum[FL_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/free_list_offsets.sv
// Mask to per-slot prefix counts (set bits strictly below each slot) plus total popcount.
module free_list_offsets #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input  logic [N-1:0]         mask,
    output logic [N-1:0][CW-1:0] offs,
    output logic [CW-1:0]        count
);

    always_comb begin
        count = '0;
        offs  = '0;
        for (int i = 0; i < N; i++) begin
            offs[i] = count;
            count   = count + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of PRNs with speculative and retire heads for one-cycle squash recovery.
// Define FREE_LIST_DEBUG_EN for state-visibility ports and the in-list bitmap checks.
module free_list
    import free_list_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N-1:0]               alloc_req,
    output logic [N-1:0][PRN_W-1:0]    alloc_prn,
    output logic                       alloc_ok,
    output logic [FL_CNT_W-1:0]        free_count,
    input  logic [NCNT_W-1:0]          retire_alloc_num,
    input  logic [N-1:0]               free_valid,
    input  logic [N-1:0][PRN_W-1:0]    free_prn,
    input  logic                       squash
`ifdef FREE_LIST_DEBUG_EN
    ,
    output logic [FL_SZ-1:0][PRN_W-1:0] entries_out,
    output logic [FL_IDX_W-1:0]         head_spec_out,
    output logic [FL_IDX_W-1:0]         head_ret_out,
    output logic [FL_IDX_W-1:0]         tail_out
`endif
);

    prn_t    entries [FL_SZ];
    fl_idx_t head_spec, head_ret, tail;
    fl_cnt_t spec_cnt, ret_cnt;

    logic [N-1:0][NCNT_W-1:0] alloc_off, free_off;
    logic [NCNT_W-1:0]        alloc_num, free_num_raw, free_num, alloc_taken;
    logic [N-1:0]             free_mask;
    logic                     do_alloc, free_fits;
    logic [FL_CNT_W:0]        occ_after_free;
    fl_cnt_t                  ret_after, ret_next, spec_next;

    always_comb begin
        free_mask = '0;
        for (int i = 0; i < N; i++)
            free_mask[i] = free_valid[i] && (free_prn[i] != '0);
    end

    free_list_offsets #(.N(N), .CW(NCNT_W)) u_alloc_offs (
        .mask  (alloc_req),
        .offs  (alloc_off),
        .count (alloc_num)
    );

    free_list_offsets #(.N(N), .CW(NCNT_W)) u_free_offs (
        .mask  (free_mask),
        .offs  (free_off),
        .count (free_num_raw)
    );

    assign free_count = spec_cnt;
    assign alloc_ok   = (FL_CNT_W'(alloc_num) <= spec_cnt);
    assign do_alloc   = alloc_ok && !squash;

    always_comb begin
        alloc_prn = '0;
        for (int i = 0; i < N; i++)
            if (alloc_req[i])
                alloc_prn[i] = entries[fl_wrap(head_spec, FL_IDX_W'(alloc_off[i]))];
    end

    // Occupancy from head_ret to tail bounds the list; an overflowing free batch is dropped whole.
    always_comb begin
        ret_after      = ret_cnt - FL_CNT_W'(retire_alloc_num);
        occ_after_free = {1'b0, ret_after} + (FL_CNT_W+1)'(free_num_raw);
        free_fits      = (occ_after_free <= (FL_CNT_W+1)'(FL_SZ));
        free_num       = free_fits ? free_num_raw : '0;
        alloc_taken    = do_alloc ? alloc_num : '0;
        ret_next       = ret_after + FL_CNT_W'(free_num);
        spec_next      = squash ? ret_next
                                : spec_cnt - FL_CNT_W'(alloc_taken) + FL_CNT_W'(free_num);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < FL_SZ; k++)
                entries[k] <= PRN_W'(ARCH_SZ + k);
            head_spec <= '0;
            head_ret  <= '0;
            tail      <= '0;
            spec_cnt  <= FL_CNT_W'(FL_SZ);
            ret_cnt   <= FL_CNT_W'(FL_SZ);
        end else begin
            if (free_fits)
                for (int i = 0; i < N; i++)
                    if (free_mask[i])
                        entries[fl_wrap(tail, FL_IDX_W'(free_off[i]))] <= free_prn[i];
            tail     <= fl_wrap(tail, FL_IDX_W'(free_num));
            head_ret <= fl_wrap(head_ret, FL_IDX_W'(retire_alloc_num));
            if (squash)
                head_spec <= fl_wrap(head_ret, FL_IDX_W'(retire_alloc_num));
            else if (do_alloc)
                head_spec <= fl_wrap(head_spec, FL_IDX_W'(alloc_num));
            spec_cnt <= spec_next;
            ret_cnt  <= ret_next;
        end
    end

`ifdef FREE_LIST_DEBUG_EN
    logic [PRF_SZ-1:0] in_list;

    // Bitmap of PRNs currently allocatable, rebuilt from the speculative window.
    always_comb begin
        in_list = '0;
        for (int k = 0; k < FL_SZ; k++)
            if (k < int'(spec_cnt))
                in_list[entries[fl_wrap(head_spec, FL_IDX_W'(k))]] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (free_valid[i] && free_prn[i] == '0)
                    $error("free_list: free of PRN 0 on slot %0d", i);
                if (free_mask[i] && in_list[free_prn[i]])
                    $error("free_list: double free of PRN %0d", free_prn[i]);
                if (do_alloc && alloc_req[i] && !in_list[alloc_prn[i]])
                    $error("free_list: alloc of PRN %0d not in list", alloc_prn[i]);
            end
            if (!free_fits)
                $error("free_list: free beyond capacity");
        end
    end

    always_comb begin
        for (int k = 0; k < FL_SZ; k++)
            entries_out[k] = entries[k];
    end
    assign head_spec_out = head_spec;
    assign head_ret_out  = head_ret;
    assign tail_out      = tail;
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a queue-based free-list model.
module tb_free_list;
    import free_list_pkg::*;

    logic                    clock;
    logic                    reset;
    logic [N-1:0]            alloc_req;
    logic [N-1:0][PRN_W-1:0] alloc_prn;
    logic                    alloc_ok;
    logic [FL_CNT_W-1:0]     free_count;
    logic [NCNT_W-1:0]       retire_alloc_num;
    logic [N-1:0]            free_valid;
    logic [N-1:0][PRN_W-1:0] free_prn;
    logic                    squash;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .alloc_req        (alloc_req),
        .alloc_prn        (alloc_prn),
        .alloc_ok         (alloc_ok),
        .free_count       (free_count),
        .retire_alloc_num (retire_alloc_num),
        .free_valid       (free_valid),
        .free_prn         (free_prn),
        .squash           (squash)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: spec_q = allocatable PRNs in order, infl_q = allocated but not yet retired,
    // pool_q = PRNs outside the list that the bench may legally free.
    int spec_q[$];
    int infl_q[$];
    int pool_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        spec_q.delete();
        infl_q.delete();
        pool_q.delete();
        for (int k = 0; k < FL_SZ; k++) spec_q.push_back(ARCH_SZ + k);
        for (int k = 1; k < ARCH_SZ; k++) pool_q.push_back(k);
    endtask

    task automatic drive(input logic rst_in, input logic [N-1:0] req, input int ret,
                         input logic [N-1:0] fv, input int p0, input int p1, input int p2,
                         input logic sq);
        reset            = rst_in;
        alloc_req        = req;
        retire_alloc_num = NCNT_W'(ret);
        free_valid       = fv;
        free_prn[0]      = PRN_W'(p0);
        free_prn[1]      = PRN_W'(p1);
        free_prn[2]      = PRN_W'(p2);
        squash           = sq;
        @(negedge clock);
    endtask

    task automatic finish_cycle();
        int pc, exp_cnt, j;
        bit exp_ok;
        int frees[$];
        if (reset) begin
            model_reset();
        end else begin
            exp_cnt = spec_q.size();
            check("free_count", int'(free_count), exp_cnt);
            check("fc_range", int'(free_count <= FL_CNT_W'(FL_SZ)), 1);
            pc = $countones(alloc_req);
            exp_ok = (pc <= exp_cnt);
            check("alloc_ok", int'(alloc_ok), int'(exp_ok));
            j = 0;
            for (int i = 0; i < N; i++) begin
                if (alloc_req[i]) begin
                    if (exp_ok) check("alloc_prn", int'(alloc_prn[i]), spec_q[j]);
                    j++;
                end else begin
                    check("alloc_prn_idle", int'(alloc_prn[i]), 0);
                end
            end
            for (int r = 0; r < int'(retire_alloc_num); r++)
                pool_q.push_back(infl_q.pop_front());
            if (!squash && exp_ok)
                for (int a = 0; a < pc; a++) infl_q.push_back(spec_q.pop_front());
            if (squash) begin
                spec_q = {infl_q, spec_q};
                infl_q.delete();
            end
            for (int i = 0; i < N; i++)
                if (free_valid[i] && free_prn[i] != 0) frees.push_back(int'(free_prn[i]));
            if (spec_q.size() + infl_q.size() + frees.size() <= FL_SZ)
                spec_q = {spec_q, frees};
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic rst_in, input logic [N-1:0] req, input int ret,
                        input logic [N-1:0] fv, input int p0, input int p1, input int p2,
                        input logic sq);
        drive(rst_in, req, ret, fv, p0, p1, p2, sq);
        finish_cycle();
    endtask

    task automatic do_reset();
        step(1'b1, 3'b000, 0, 3'b000, 0, 0, 0, 1'b0);
        step(1'b1, 3'b000, 0, 3'b000, 0, 0, 0, 1'b0);
    endtask

    task automatic random_cycle();
        logic [N-1:0] req, fv;
        int ret, room, nf, need, idx;
        int p[3];
        logic sq;
        req  = N'($urandom_range(0, 7));
        ret  = $urandom_range(0, (infl_q.size() < 3) ? infl_q.size() : 3);
        room = FL_SZ - (spec_q.size() + infl_q.size() - ret);
        nf   = 3;
        if (room < nf) nf = room;
        if (pool_q.size() < nf) nf = pool_q.size();
        nf   = $urandom_range(0, nf);
        need = nf;
        fv   = '0;
        for (int i = 0; i < 3; i++) begin
            p[i] = 0;
            if (need > 0 && ($urandom_range(0, 1) == 1 || (3 - i) == need)) begin
                idx = $urandom_range(0, pool_q.size() - 1);
                p[i] = pool_q[idx];
                pool_q.delete(idx);
                fv[i] = 1'b1;
                need--;
            end else if ($urandom_range(0, 7) == 0) begin
                fv[i] = 1'b1;
            end
        end
        sq = ($urandom_range(0, 15) == 0);
        step(1'b0, req, ret, fv, p[0], p[1], p[2], sq);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; alloc_req = '0; retire_alloc_num = '0;
        free_valid = '0; free_prn = '0; squash = 1'b0;
        do_reset();

        // Reset state
        drive(1'b0, 3'b000, 0, 3'b000, 0, 0, 0, 1'b0);
        check("rst_free_count", int'(free_count), FL_SZ);
        check("rst_alloc_ok", int'(alloc_ok), 1);
        finish_cycle();

        // First allocation after reset
        drive(1'b0, 3'b111, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t1_prn0", int'(alloc_prn[0]), 32);
        check("t1_prn1", int'(alloc_prn[1]), 33);
        check("t1_prn2", int'(alloc_prn[2]), 34);
        check("t1_ok", int'(alloc_ok), 1);
        finish_cycle();
        drive(1'b0, 3'b000, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t1_count", int'(free_count), FL_SZ - 3);
        finish_cycle();

        // Drain to one entry, then all-or-nothing
        repeat (8) step(1'b0, 3'b111, 0, 3'b000, 0, 0, 0, 1'b0);
        drive(1'b0, 3'b011, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t2_count1", int'(free_count), 1);
        check("t2_ok_blocked", int'(alloc_ok), 0);
        finish_cycle();
        drive(1'b0, 3'b010, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t2_held", int'(free_count), 1);
        check("t2_prn1", int'(alloc_prn[1]), 59);
        finish_cycle();
        drive(1'b0, 3'b001, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t2_empty_ok", int'(alloc_ok), 0);
        finish_cycle();
        // Empty list: a free lands while the same cycle's request is refused
        drive(1'b0, 3'b001, 3, 3'b111, 5, 0, 9, 1'b0);
        check("t3_empty_req", int'(alloc_ok), 0);
        finish_cycle();
        drive(1'b0, 3'b011, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t3_count", int'(free_count), 2);
        check("t3_first", int'(alloc_prn[0]), 5);
        check("t3_second", int'(alloc_prn[1]), 9);
        finish_cycle();
        drive(1'b0, 3'b000, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t3_empty_zero_req", int'(alloc_ok), 1);
        finish_cycle();

        // Free beyond capacity while full is dropped
        do_reset();
        step(1'b0, 3'b000, 0, 3'b001, 7, 0, 0, 1'b0);
        drive(1'b0, 3'b111, 0, 3'b000, 0, 0, 0, 1'b0);
        check("ovf_count", int'(free_count), FL_SZ);
        check("ovf_prn0", int'(alloc_prn[0]), 32);
        check("ovf_prn2", int'(alloc_prn[2]), 34);
        finish_cycle();

        // Squash with same-cycle retire
        do_reset();
        step(1'b0, 3'b111, 0, 3'b000, 0, 0, 0, 1'b0);
        step(1'b0, 3'b111, 0, 3'b000, 0, 0, 0, 1'b0);
        step(1'b0, 3'b000, 2, 3'b000, 0, 0, 0, 1'b1);
        drive(1'b0, 3'b001, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t4_count", int'(free_count), FL_SZ - 2);
        check("t4_prn", int'(alloc_prn[0]), 34);
        finish_cycle();

        // Long randomized run exercising wrap, squash and frees
        for (int c = 0; c < 700; c++) random_cycle();

        // Reset mid-stream overrides squash, alloc and free
        step(1'b1, 3'b111, 0, 3'b111, 1, 2, 3, 1'b1);
        drive(1'b0, 3'b111, 0, 3'b000, 0, 0, 0, 1'b0);
        check("t6_count", int'(free_count), FL_SZ);
        check("t6_prn0", int'(alloc_prn[0]), 32);
        check("t6_prn1", int'(alloc_prn[1]), 33);
        check("t6_prn2", int'(alloc_prn[2]), 34);
        finish_cycle();
        for (int c = 0; c < 200; c++) random_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
